sram_sync: RTL and testbench
============================

# sram_sync

Parametrised single-port synchronous SRAM, successor to the team's asynchronous chip-enable SRAM. Replaces the active-low ce/oe/we strobes and tri-state data bus with a clocked valid/ready request port, separate read and write data buses, byte-lane write enables, a selectable read pipeline depth and an optional hardware clear sequence after reset. Sits between core logic and on-chip storage wherever a deterministic, clocked memory is required.

## Interface
- ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 16, word width; must be a multiple of 8
- READ_LAT, 1, read latency in cycles; legal values 1 or 2
- INIT_CLEAR, 1, 1 = zero the whole array after reset; 0 = skip
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request can be accepted this cycle
- req_we  input  1  1 = write, 0 = read
- req_be  input  DATA_WIDTH/8  byte-lane write enables; ignored on reads
- req_adr  input  ADDR_WIDTH  word address
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  read data valid, one-cycle pulse per read
- rsp_rdata  output  DATA_WIDTH  read data
- busy  output  1  clear sequence in progress

## Operation
- FSM states: CLEAR, IDLE.
- reset asserted: state = CLEAR if INIT_CLEAR else IDLE; clear counter = 0; read pipeline flushed.
- CLEAR: one word written to zero per cycle at address = counter, counter increments; req_ready = 0, busy = 1. After writing address DEPTH-1, next state IDLE.
- IDLE: req_ready = 1 every cycle, busy = 0; one request accepted per cycle when req_valid && req_ready.
- Write accept: for each lane i with req_be[i] = 1, bits [8i+7:8i] of mem[req_adr] take req_wdata at that edge; other lanes unchanged. req_be = 0 is accepted as a no-op. No response generated.
- Read accept: rsp_valid pulses high exactly READ_LAT cycles later for one cycle with mem[req_adr]. Back-to-back reads stream one response per cycle, in order.
- Read-after-write: a read accepted the cycle after a write to the same address returns the newly written bytes.
- rsp_rdata holds its last value while rsp_valid = 0.
- Requests presented while req_ready = 0 are ignored, not queued.
- Memory contents are not reset by reset except through the clear sequence.

## Timing
- Reset values: req_ready = !INIT_CLEAR; busy = INIT_CLEAR; rsp_valid = 0; rsp_rdata = 0.
- Clear sequence duration: exactly 2**ADDR_WIDTH cycles after reset deassertion; req_ready rises on the following cycle.
- Read latency: accept at edge N -> rsp_valid high during cycle after edge N+READ_LAT-1 (READ_LAT=1: registered array output; READ_LAT=2: extra output register).
- Throughput: 1 request/cycle in IDLE, reads and writes freely interleaved.
- Reset mid-clear: counter returns to 0 and clear restarts from address 0.
- Reset mid-read: in-flight responses dropped; rsp_valid = 0 from reset assertion.
- Counter width ADDR_WIDTH+1 bits so terminal count is detected without wrap ambiguity.

## Structure
- Package sram_pkg: state enum typedef (CLEAR, IDLE); localparam helpers for DEPTH = 2**ADDR_WIDTH and NBYTES = DATA_WIDTH/8.
- Sub-module sram_array: storage, byte-lane write, registered read port; no reset on storage. Top level holds FSM, clear counter, request mux (clear writes vs. user requests) and READ_LAT valid/data pipeline.

## Test plan
- ADDR_WIDTH=4, INIT_CLEAR=1: release reset -> busy high exactly 16 cycles, req_ready high on cycle 17, read of every address returns 0x0000.
- Write 0xBEEF to 0x3 with be=2'b11, then write 0x12xx with be=2'b10 to 0x3, read 0x3 -> rsp_rdata = 0x12EF.
- READ_LAT=2: reads to 0x1,0x2,0x3 on consecutive cycles -> three consecutive rsp_valid pulses starting 2 cycles after first accept, data in order.
- Write 0xA5A5 to 0x7 then read 0x7 on the very next cycle -> 0xA5A5.
- Assert reset at clear count 5 -> clear restarts at 0 and still takes full 2**ADDR_WIDTH cycles; assert reset with a read in flight -> no rsp_valid pulse.
- INIT_CLEAR=0: req_ready = 1 immediately out of reset; req_valid with be=0 write -> contents unchanged on readback.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the synchronous single-port SRAM.
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    function automatic int calc_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int calc_nbytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sram_sync_if.sv
// Request/response port of sram_sync: valid/ready request, read response, clear status.
interface sram_sync_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [DATA_WIDTH/8-1:0]   req_be;
    logic [ADDR_WIDTH-1:0]     req_adr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      busy;

    modport master (
        output req_valid, req_we, req_be, req_adr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_be, req_adr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/sram_array.sv
// Storage array with byte-lane writes and a registered read port.
module sram_array
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [ADDR_WIDTH-1:0]   i_adr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic                    i_re,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int DEPTH  = calc_depth(ADDR_WIDTH);
    localparam int NBYTES = calc_nbytes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // NOTE: the array has no reset branch; zeroing is the top level's clear sequence.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (i_be[i]) begin
                    r_mem[i_adr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register only loads on a read, so the last data is held between reads.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_adr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_sync.sv
// Synchronous single-port SRAM: clear FSM, request mux and READ_LAT response pipeline.
module sram_sync
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int READ_LAT   = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    sram_sync_if.slave  bus
);

    localparam int                  DEPTH       = calc_depth(ADDR_WIDTH);
    localparam int                  NBYTES      = calc_nbytes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] LAST_ADR    = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam state_t              RESET_STATE = (INIT_CLEAR != 0) ? CLEAR : IDLE;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH:0]   r_clr_cnt;
    logic                  w_ready;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_rd_accept;
    logic                  w_arr_we;
    logic [NBYTES-1:0]     w_arr_be;
    logic [ADDR_WIDTH-1:0] w_arr_adr;
    logic [DATA_WIDTH-1:0] w_arr_wdata;
    logic [DATA_WIDTH-1:0] w_arr_rdata;
    logic                  r_vld1;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clr_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            CLEAR: begin
                w_busy = 1'b1;
                if (r_clr_cnt == LAST_ADR) begin
                    w_state_next = IDLE;
                end
            end
            IDLE: begin
                w_ready = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_accept    = bus.req_valid && w_ready;
    assign w_rd_accept = w_accept && !bus.req_we;

    // Clear writes own the array port while busy; user requests otherwise.
    always_comb begin
        w_arr_we    = w_accept && bus.req_we;
        w_arr_be    = bus.req_be;
        w_arr_adr   = bus.req_adr;
        w_arr_wdata = bus.req_wdata;
        if (r_state == CLEAR) begin
            w_arr_we    = 1'b1;
            w_arr_be    = '1;
            w_arr_adr   = r_clr_cnt[ADDR_WIDTH-1:0];
            w_arr_wdata = '0;
        end
    end

    sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_arr_we),
        .i_be    (w_arr_be),
        .i_adr   (w_arr_adr),
        .i_wdata (w_arr_wdata),
        .i_re    (w_rd_accept),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld1 <= 1'b0;
        end else begin
            r_vld1 <= w_rd_accept;
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic                  r_vld2;
        logic [DATA_WIDTH-1:0] r_rdata2;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_vld2   <= 1'b0;
                r_rdata2 <= '0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_rdata2 <= w_arr_rdata;
                end
            end
        end

        assign bus.rsp_valid = r_vld2;
        assign bus.rsp_rdata = r_rdata2;
    end else begin : g_lat1
        assign bus.rsp_valid = r_vld1;
        assign bus.rsp_rdata = w_arr_rdata;
    end

    assign bus.req_ready = w_ready;
    assign bus.busy      = w_busy;

endmodule

// File: tb/tb_sram_sync.sv
// Directed bench: three sram_sync instances (clear+lat1, clear+lat2, no-clear+lat1) on shared stimulus.
module tb_sram_sync;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst0, rst1, rst2;
    logic          req_valid, req_we;
    logic [NB-1:0] req_be;
    logic [AW-1:0] req_adr;
    logic [DW-1:0] req_wdata;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];

    always #5 clk = ~clk;

    sram_sync_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    sram_sync_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    sram_sync_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

    assign bus0.req_valid = req_valid;
    assign bus0.req_we    = req_we;
    assign bus0.req_be    = req_be;
    assign bus0.req_adr   = req_adr;
    assign bus0.req_wdata = req_wdata;
    assign bus1.req_valid = req_valid;
    assign bus1.req_we    = req_we;
    assign bus1.req_be    = req_be;
    assign bus1.req_adr   = req_adr;
    assign bus1.req_wdata = req_wdata;
    assign bus2.req_valid = req_valid;
    assign bus2.req_we    = req_we;
    assign bus2.req_be    = req_be;
    assign bus2.req_adr   = req_adr;
    assign bus2.req_wdata = req_wdata;

    sram_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1), .INIT_CLEAR(0)) u_dut0 (
        .i_clk (clk), .i_rst (rst0), .bus (bus0)
    );
    sram_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1), .INIT_CLEAR(1)) u_dut1 (
        .i_clk (clk), .i_rst (rst1), .bus (bus1)
    );
    sram_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(2), .INIT_CLEAR(1)) u_dut2 (
        .i_clk (clk), .i_rst (rst2), .bus (bus2)
    );

    // Response collectors
    always @(negedge clk) begin
        if (bus0.rsp_valid === 1'b1) q0.push_back(bus0.rsp_rdata);
        if (bus1.rsp_valid === 1'b1) q1.push_back(bus1.rsp_rdata);
        if (bus2.rsp_valid === 1'b1) q2.push_back(bus2.rsp_rdata);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = '0;
        req_adr   = '0;
        req_wdata = '0;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = be;
        req_adr   = a;
        req_wdata = d;
    endtask

    task automatic drive_read(input logic [AW-1:0] a);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_be    = '1;
        req_adr   = a;
        req_wdata = 16'hFFFF;
    endtask

    task automatic clear_q;
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic count_busy(output int n1, output int n2);
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus1.busy) n1++;
            if (bus2.busy) n2++;
            if (!bus1.busy && !bus2.busy) break;
            tick();
        end
    endtask

    task automatic test_reset;
        logic [18:0] got;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        drive_idle();
        tick();
        tick();
        got = {bus1.req_ready, bus1.busy, bus1.rsp_valid, bus1.rsp_rdata};
        checks++;
        if (got !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_dut1: got %h expected %h", got, {1'b0, 1'b1, 1'b0, 16'h0000});
        end
        got = {bus2.req_ready, bus2.busy, bus2.rsp_valid, bus2.rsp_rdata};
        checks++;
        if (got !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_dut2: got %h expected %h", got, {1'b0, 1'b1, 1'b0, 16'h0000});
        end
        got = {bus0.req_ready, bus0.busy, bus0.rsp_valid, bus0.rsp_rdata};
        checks++;
        if (got !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_dut0: got %h expected %h", got, {1'b1, 1'b0, 1'b0, 16'h0000});
        end
    endtask

    task automatic test_clear_sequence;
        int n1, n2;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        count_busy(n1, n2);
        checks++;
        if (n1 != 16) begin
            errors++;
            $display("FAIL clear_len_dut1: got %0d cycles expected 16", n1);
        end
        checks++;
        if (n2 != 16) begin
            errors++;
            $display("FAIL clear_len_dut2: got %0d cycles expected 16", n2);
        end
        checks++;
        if ({bus1.req_ready, bus2.req_ready} !== 2'b11) begin
            errors++;
            $display("FAIL clear_ready: got %b expected 11", {bus1.req_ready, bus2.req_ready});
        end
    endtask

    task automatic test_read_all_zero;
        int nz;
        clear_q();
        for (int a = 0; a < 16; a++) begin
            drive_read(AW'(a));
            tick();
        end
        drive_idle();
        repeat (3) tick();
        checks++;
        if (q1.size() != 16 || q2.size() != 16) begin
            errors++;
            $display("FAIL zero_count: got %0d/%0d responses expected 16/16", q1.size(), q2.size());
        end
        for (int i = 0; i < q1.size(); i++) begin
            checks++;
            if (q1[i] !== 16'h0000) begin
                errors++;
                $display("FAIL zero_dut1_adr%0d: got %h expected 0000", i, q1[i]);
            end
        end
        nz = 0;
        for (int i = 0; i < q2.size(); i++) if (q2[i] !== 16'h0000) nz++;
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL zero_dut2: got %0d nonzero words expected 0", nz);
        end
    endtask

    task automatic test_byte_lanes;
        clear_q();
        drive_write(4'h3, 16'hBEEF, 2'b11);
        tick();
        drive_write(4'h3, 16'h1234, 2'b10);
        tick();
        drive_read(4'h3);
        tick();
        drive_idle();
        repeat (3) tick();
        checks++;
        if (q0.size() != 1 || q0[0] !== 16'h12EF) begin
            errors++;
            $display("FAIL byte_lane_dut0: got %0d words first %h expected 1 word 12ef", q0.size(), q0[0]);
        end
        checks++;
        if (q1.size() != 1 || q1[0] !== 16'h12EF) begin
            errors++;
            $display("FAIL byte_lane_dut1: got %0d words first %h expected 1 word 12ef", q1.size(), q1[0]);
        end
        checks++;
        if (q2.size() != 1 || q2[0] !== 16'h12EF) begin
            errors++;
            $display("FAIL byte_lane_dut2: got %0d words first %h expected 1 word 12ef", q2.size(), q2[0]);
        end
    endtask

    task automatic test_read_after_write;
        drive_write(4'h7, 16'hA5A5, 2'b11);
        tick();
        drive_read(4'h7);
        tick();
        checks++;
        if ({bus1.rsp_valid, bus1.rsp_rdata} !== {1'b1, 16'hA5A5}) begin
            errors++;
            $display("FAIL raw_lat1: got v=%b d=%h expected v=1 d=a5a5", bus1.rsp_valid, bus1.rsp_rdata);
        end
        checks++;
        if (bus2.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL raw_lat2_early: got v=%b expected v=0", bus2.rsp_valid);
        end
        drive_idle();
        tick();
        checks++;
        if ({bus1.rsp_valid, bus1.rsp_rdata} !== {1'b0, 16'hA5A5}) begin
            errors++;
            $display("FAIL raw_lat1_hold: got v=%b d=%h expected v=0 d=a5a5", bus1.rsp_valid, bus1.rsp_rdata);
        end
        checks++;
        if ({bus2.rsp_valid, bus2.rsp_rdata} !== {1'b1, 16'hA5A5}) begin
            errors++;
            $display("FAIL raw_lat2: got v=%b d=%h expected v=1 d=a5a5", bus2.rsp_valid, bus2.rsp_rdata);
        end
        tick();
        checks++;
        if ({bus2.rsp_valid, bus2.rsp_rdata} !== {1'b0, 16'hA5A5}) begin
            errors++;
            $display("FAIL raw_lat2_hold: got v=%b d=%h expected v=0 d=a5a5", bus2.rsp_valid, bus2.rsp_rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic          exp_v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [DW-1:0] exp_d [5] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h0000};
        drive_write(4'h1, 16'h1111, 2'b11);
        tick();
        drive_write(4'h2, 16'h2222, 2'b11);
        tick();
        drive_write(4'h3, 16'h3333, 2'b11);
        tick();
        clear_q();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive_read(AW'(i + 1));
            else       drive_idle();
            tick();
            checks++;
            if (bus2.rsp_valid !== exp_v[i] || (exp_v[i] && bus2.rsp_rdata !== exp_d[i])) begin
                errors++;
                $display("FAIL b2b_lat2_step%0d: got v=%b d=%h expected v=%b d=%h",
                         i, bus2.rsp_valid, bus2.rsp_rdata, exp_v[i], exp_d[i]);
            end
        end
        checks++;
        if (q1.size() != 3 || q1[0] !== 16'h1111 || q1[1] !== 16'h2222 || q1[2] !== 16'h3333) begin
            errors++;
            $display("FAIL b2b_lat1_order: got %0d words %h %h %h expected 1111 2222 3333",
                     q1.size(), q1[0], q1[1], q1[2]);
        end
    endtask

    task automatic test_reset_mid_clear;
        int n1, n2;
        rst1 = 1'b1; rst2 = 1'b1;
        tick();
        rst1 = 1'b0; rst2 = 1'b0;
        repeat (5) tick();
        rst1 = 1'b1; rst2 = 1'b1;
        #1;
        checks++;
        if ({bus1.busy, bus1.req_ready, bus2.busy, bus2.req_ready} !== 4'b1010) begin
            errors++;
            $display("FAIL midclear_reset_state: got %b expected 1010",
                     {bus1.busy, bus1.req_ready, bus2.busy, bus2.req_ready});
        end
        tick();
        rst1 = 1'b0; rst2 = 1'b0;
        count_busy(n1, n2);
        checks++;
        if (n1 != 16 || n2 != 16) begin
            errors++;
            $display("FAIL midclear_restart_len: got %0d/%0d cycles expected 16/16", n1, n2);
        end
        clear_q();
        drive_read(4'h7);
        tick();
        drive_read(4'h3);
        tick();
        drive_idle();
        repeat (3) tick();
        checks++;
        if (q1.size() != 2 || q1[0] !== 16'h0000 || q1[1] !== 16'h0000) begin
            errors++;
            $display("FAIL midclear_zero_dut1: got %0d words %h %h expected 0000 0000", q1.size(), q1[0], q1[1]);
        end
        checks++;
        if (q2.size() != 2 || q2[0] !== 16'h0000 || q2[1] !== 16'h0000) begin
            errors++;
            $display("FAIL midclear_zero_dut2: got %0d words %h %h expected 0000 0000", q2.size(), q2[0], q2[1]);
        end
        checks++;
        if (q0.size() != 2 || q0[0] !== 16'hA5A5 || q0[1] !== 16'h3333) begin
            errors++;
            $display("FAIL noclear_kept_dut0: got %0d words %h %h expected a5a5 3333", q0.size(), q0[0], q0[1]);
        end
    endtask

    task automatic test_reset_mid_read;
        int pulses;
        clear_q();
        drive_read(4'h7);
        tick();
        checks++;
        if ({bus0.rsp_valid, bus0.rsp_rdata} !== {1'b1, 16'hA5A5}) begin
            errors++;
            $display("FAIL midread_pre_dut0: got v=%b d=%h expected v=1 d=a5a5", bus0.rsp_valid, bus0.rsp_rdata);
        end
        rst0 = 1'b1; rst2 = 1'b1;
        drive_idle();
        #1;
        checks++;
        if ({bus0.rsp_valid, bus0.rsp_rdata} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL midread_flush_dut0: got v=%b d=%h expected v=0 d=0000", bus0.rsp_valid, bus0.rsp_rdata);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus2.rsp_valid !== 1'b0) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midread_flush_dut2: got %0d valid cycles expected 0", pulses);
        end
    endtask

    task automatic test_init_clear_off;
        int n1, n2;
        rst0 = 1'b0; rst2 = 1'b0;
        #1;
        checks++;
        if ({bus0.req_ready, bus0.busy, bus2.busy} !== 3'b101) begin
            errors++;
            $display("FAIL noclear_ready: got %b expected 101", {bus0.req_ready, bus0.busy, bus2.busy});
        end
        clear_q();
        drive_write(4'h9, 16'h6789, 2'b11);
        tick();
        drive_write(4'h9, 16'hFFFF, 2'b00);
        tick();
        drive_read(4'h9);
        tick();
        drive_idle();
        repeat (2) tick();
        checks++;
        if (q0.size() != 1 || q0[0] !== 16'h6789) begin
            errors++;
            $display("FAIL be0_noop_dut0: got %0d words first %h expected 1 word 6789", q0.size(), q0[0]);
        end
        checks++;
        if (q1.size() != 1 || q1[0] !== 16'h6789) begin
            errors++;
            $display("FAIL be0_noop_dut1: got %0d words first %h expected 1 word 6789", q1.size(), q1[0]);
        end
        checks++;
        if (q2.size() != 0) begin
            errors++;
            $display("FAIL busy_ignore_dut2: got %0d responses expected 0", q2.size());
        end
        count_busy(n1, n2);
        checks++;
        if (bus2.req_ready !== 1'b1 || n2 >= 40) begin
            errors++;
            $display("FAIL reclear_done_dut2: got ready=%b after %0d cycles expected ready=1", bus2.req_ready, n2);
        end
        clear_q();
        drive_read(4'h9);
        tick();
        drive_idle();
        repeat (3) tick();
        checks++;
        if (q2.size() != 1 || q2[0] !== 16'h0000) begin
            errors++;
            $display("FAIL reclear_zero_dut2: got %0d words first %h expected 1 word 0000", q2.size(), q2[0]);
        end
    endtask

    initial begin
        test_reset();
        test_clear_sequence();
        test_read_all_zero();
        test_byte_lanes();
        test_read_after_write();
        test_back_to_back();
        test_reset_mid_clear();
        test_reset_mid_read();
        test_init_clear_off();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
